// File: rtl/tty_writer_pkg.sv
// Shared definitions for the text-terminal framebuffer writer.
//   COLS/ROWS/WPR : default screen geometry (columns, rows, 64-bit words per row)
//   state_e       : writer FSM states
//   Code*         : recognised control bytes and the printable range
//   cell_word()   : builds a 64-bit word holding one cell replicated in all four lanes
package tty_pkg;

  localparam int unsigned COLS = 128;
  localparam int unsigned ROWS = 32;
  localparam int unsigned WPR  = 32;

  // Cell layout: {1'b0, bg[2:0], fg[3:0], char[7:0]}
  localparam int unsigned CharW = 8;
  localparam int unsigned AttrW = 7;
  localparam int unsigned CellW = 1 + AttrW + CharW;

  typedef enum logic [2:0] {
    StIdle,
    StPut,
    StScrRd,
    StScrWr,
    StClrRow,
    StClrAll
  } state_e;

  localparam logic [7:0] CodeBs       = 8'h08;
  localparam logic [7:0] CodeTab      = 8'h09;
  localparam logic [7:0] CodeLf       = 8'h0A;
  localparam logic [7:0] CodeFf       = 8'h0C;
  localparam logic [7:0] CodeCr       = 8'h0D;
  localparam logic [7:0] CodeSpace    = 8'h20;
  localparam logic [7:0] CodePrintMax = 8'h7E;

  function automatic logic [4*CellW-1:0] cell_word(logic [AttrW-1:0] attr,
                                                   logic [CharW-1:0] ch);
    return {4{1'b0, attr, ch}};
  endfunction

endpackage

// File: rtl/tty_writer.sv
// Character stream to framebuffer writer with cursor handling and hardware scroll.
//   clk_data, irst          : clock, synchronous active-high reset
//   in_valid/in_char/in_attr: byte offered with its colour attribute
//   in_ready                : byte accepted this cycle (only when idle)
//   mem_en/mem_we/mem_addr/mem_din/mem_dout : single-port 64-bit framebuffer port
//   cur_row/cur_col         : cursor position
//   busy                    : FSM not idle
module tty_writer #(
  parameter int unsigned COLS = tty_pkg::COLS,
  parameter int unsigned ROWS = tty_pkg::ROWS,
  parameter int unsigned WPR  = tty_pkg::WPR
) (
  input  logic        clk_data,
  input  logic        irst,
  input  logic        in_valid,
  input  logic [7:0]  in_char,
  input  logic [6:0]  in_attr,
  output logic        in_ready,
  output logic        mem_en,
  output logic [7:0]  mem_we,
  output logic [10:0] mem_addr,
  output logic [63:0] mem_din,
  input  logic [63:0] mem_dout,
  output logic [4:0]  cur_row,
  output logic [6:0]  cur_col,
  output logic        busy
);
  import tty_pkg::*;

  localparam logic [4:0] LastRow    = 5'(ROWS - 1);
  localparam logic [6:0] LastCol    = 7'(COLS - 1);
  localparam logic [9:0] LastWord   = 10'(ROWS * WPR - 1);
  localparam logic [9:0] ScrollBase = 10'(WPR);
  localparam logic [9:0] LastRowBase = 10'(ROWS * WPR - WPR);

  state_e     state_q, state_d;
  logic [4:0] row_q, row_d;
  logic [6:0] col_q, col_d;
  // Shared word index: copy source during scroll, target during clears
  logic [9:0] idx_q, idx_d;
  logic [7:0] char_q, char_d;
  logic [6:0] attr_q, attr_d;

  logic       accept;
  logic       newline;
  logic [7:0] tab_col;

  assign in_ready = (state_q == StIdle) && !irst;
  assign busy     = (state_q != StIdle) && !irst;
  assign accept   = in_valid && in_ready;
  assign cur_row  = row_q;
  assign cur_col  = col_q;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    idx_d    = idx_q;
    char_d   = char_q;
    attr_d   = attr_q;
    mem_en   = 1'b0;
    mem_we   = 8'h00;
    mem_addr = 11'd0;
    mem_din  = 64'd0;
    newline  = 1'b0;
    tab_col  = ({1'b0, col_q} | 8'h07) + 8'd1;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          char_d = in_char;
          attr_d = in_attr;
          if (in_char >= CodeSpace && in_char <= CodePrintMax) begin
            state_d = StPut;
          end else begin
            case (in_char)
              CodeCr:  col_d = 7'd0;
              CodeLf:  newline = 1'b1;
              CodeBs:  if (col_q != 7'd0) col_d = col_q - 7'd1;
              CodeTab: begin
                if (tab_col > {1'b0, LastCol}) begin
                  col_d   = 7'd0;
                  newline = 1'b1;
                end else begin
                  col_d = tab_col[6:0];
                end
              end
              CodeFf: begin
                state_d = StClrAll;
                idx_d   = 10'd0;
              end
              default: ;
            endcase
          end
        end
      end
      StPut: begin
        mem_en   = 1'b1;
        mem_addr = {1'b0, row_q, col_q[6:2]};
        mem_din  = cell_word(attr_q, char_q);
        mem_we   = 8'h03 << {col_q[1:0], 1'b0};
        state_d  = StIdle;
        if (col_q == LastCol) begin
          col_d   = 7'd0;
          newline = 1'b1;
        end else begin
          col_d = col_q + 7'd1;
        end
      end
      StScrRd: begin
        mem_en   = 1'b1;
        mem_addr = {1'b0, idx_q};
        state_d  = StScrWr;
      end
      StScrWr: begin
        // Read data from the previous cycle goes one row up
        mem_en   = 1'b1;
        mem_we   = 8'hFF;
        mem_addr = {1'b0, idx_q - ScrollBase};
        mem_din  = mem_dout;
        if (idx_q == LastWord) begin
          idx_d   = LastRowBase;
          state_d = StClrRow;
        end else begin
          idx_d   = idx_q + 10'd1;
          state_d = StScrRd;
        end
      end
      StClrRow, StClrAll: begin
        mem_en   = 1'b1;
        mem_we   = 8'hFF;
        mem_addr = {1'b0, idx_q};
        mem_din  = cell_word(attr_q, CodeSpace);
        idx_d    = idx_q + 10'd1;
        if (idx_q == LastWord) begin
          state_d = StIdle;
          if (state_q == StClrAll) begin
            row_d = 5'd0;
            col_d = 7'd0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Newline from LF, TAB overflow or end-of-row print; bottom row scrolls
    if (newline) begin
      if (row_q == LastRow) begin
        state_d = StScrRd;
        idx_d   = ScrollBase;
      end else begin
        row_d = row_q + 5'd1;
      end
    end

    // Reset silences the memory port immediately, even mid-scroll
    if (irst) begin
      mem_en   = 1'b0;
      mem_we   = 8'h00;
      mem_addr = 11'd0;
      mem_din  = 64'd0;
    end
  end

  always_ff @(posedge clk_data) begin
    if (irst) begin
      state_q <= StIdle;
      row_q   <= 5'd0;
      col_q   <= 7'd0;
      idx_q   <= 10'd0;
      char_q  <= 8'd0;
      attr_q  <= 7'd0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      char_q  <= char_d;
      attr_q  <= attr_d;
    end
  end

endmodule

// File: tb/tb_tty_writer.sv
module tb_tty_writer;

  logic        clk_data = 1'b0;
  logic        irst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_char = 8'h00;
  logic [6:0]  in_attr = 7'h00;
  logic        in_ready;
  logic        mem_en;
  logic [7:0]  mem_we;
  logic [10:0] mem_addr;
  logic [63:0] mem_din;
  logic [63:0] mem_dout;
  logic [4:0]  cur_row;
  logic [6:0]  cur_col;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk_data = ~clk_data;

  tty_writer dut (
    .clk_data (clk_data),
    .irst     (irst),
    .in_valid (in_valid),
    .in_char  (in_char),
    .in_attr  (in_attr),
    .in_ready (in_ready),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .cur_row  (cur_row),
    .cur_col  (cur_col),
    .busy     (busy)
  );

  // Framebuffer model
  logic [63:0] ram [0:1023];
  logic        preload = 1'b0;

  always @(posedge clk_data) begin
    if (preload) begin
      for (int n = 0; n < 1024; n++) ram[n] <= 64'(n);
    end else if (mem_en) begin
      if (mem_we == 8'h00) mem_dout <= ram[mem_addr[9:0]];
      else for (int b = 0; b < 8; b++)
        if (mem_we[b]) ram[mem_addr[9:0]][8*b +: 8] <= mem_din[8*b +: 8];
    end
  end

  typedef struct packed {
    logic [10:0] addr;
    logic [7:0]  we;
    logic [63:0] din;
    logic [31:0] cyc;
  } wr_t;

  wr_t  obs_q[$];
  wr_t  exp_q[$];
  int   acc_cnt = 0;
  logic [31:0] cyc = 0;

  always @(negedge clk_data) begin
    cyc <= cyc + 1;
    if (mem_en) begin
      acc_cnt <= acc_cnt + 1;
      if (mem_we != 8'h00) obs_q.push_back('{mem_addr, mem_we, mem_din, cyc});
    end
  end

  task automatic send(input logic [7:0] ch, input logic [6:0] at);
    int n = 0;
    @(negedge clk_data);
    while (!in_ready && n < 6000) begin
      @(negedge clk_data);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    in_valid = 1'b1;
    in_char  = ch;
    in_attr  = at;
    @(posedge clk_data);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_busy(output int n, output int ready_hi);
    n = 0;
    ready_hi = 0;
    @(negedge clk_data);
    while (busy && n < 6000) begin
      n++;
      if (in_ready) ready_hi++;
      @(negedge clk_data);
    end
  endtask

  task automatic do_reset();
    irst = 1'b1;
    @(posedge clk_data);
    #1 irst = 1'b0;
  endtask

  task automatic do_preload();
    preload = 1'b1;
    @(posedge clk_data);
    #1 preload = 1'b0;
  endtask

  task automatic test_reset();
    irst = 1'b1;
    repeat (3) @(posedge clk_data);
    @(negedge clk_data);
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_din, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: en=%b we=%h addr=%h din=%h busy=%b, required all 0",
               mem_en, mem_we, mem_addr, mem_din, busy);
    end
    @(posedge clk_data);
    #1 irst = 1'b0;
    @(negedge clk_data);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
    end
    checks++;
    if ({cur_row, cur_col} !== 12'd0) begin
      errors++;
      $display("FAIL reset_cursor: row=%0d col=%0d, required 0 0", cur_row, cur_col);
    end
  endtask

  task automatic test_put();
    int n, r, base;
    wr_t e, o;
    do_reset();
    base = obs_q.size();
    exp_q.push_back('{11'd0, 8'h03, {4{16'h0F41}}, 32'd0});
    send(8'h41, 7'h0F);
    run_busy(n, r);
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL put_busy: busy cycles %0d, required 1", n);
    end
    checks++;
    if (cur_col !== 7'd1) begin
      errors++;
      $display("FAIL put_col: cur_col=%0d, required 1", cur_col);
    end
    checks++;
    if (obs_q.size() - base !== 1) begin
      errors++;
      $display("FAIL put_count: %0d writes, required 1", obs_q.size() - base);
    end else begin
      e = exp_q.pop_front();
      o = obs_q[base];
      checks++;
      if ({o.addr, o.we, o.din} !== {e.addr, e.we, e.din}) begin
        errors++;
        $display("FAIL put_write: addr=%h we=%h din=%h, required addr=%h we=%h din=%h",
                 o.addr, o.we, o.din, e.addr, e.we, e.din);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n, r, base;
    logic [7:0] chs [4];
    wr_t e, o;
    chs = '{8'h42, 8'h43, 8'h44, 8'h45};
    base = obs_q.size();
    for (int i = 0; i < 4; i++) begin
      // Cursor starts at column 1 after the previous test
      exp_q.push_back('{11'((i + 1) / 4), 8'(8'h03 << (2 * ((i + 1) % 4))),
                        {4{1'b0, 7'h3A, chs[i]}}, 32'd0});
      send(chs[i], 7'h3A);
    end
    run_busy(n, r);
    checks++;
    if (obs_q.size() - base !== 4) begin
      errors++;
      $display("FAIL b2b_count: %0d writes, required 4", obs_q.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        e = exp_q.pop_front();
        o = obs_q[base + i];
        checks++;
        if ({o.addr, o.we, o.din} !== {e.addr, e.we, e.din}) begin
          errors++;
          $display("FAIL b2b_write%0d: addr=%h we=%h din=%h, required addr=%h we=%h din=%h",
                   i, o.addr, o.we, o.din, e.addr, e.we, e.din);
        end
        if (i > 0) begin
          checks++;
          if (o.cyc - obs_q[base + i - 1].cyc !== 32'd2) begin
            errors++;
            $display("FAIL b2b_spacing%0d: %0d cycles, required 2",
                     i, o.cyc - obs_q[base + i - 1].cyc);
          end
        end
      end
    end
    checks++;
    if (ram[0] !== {16'h3A44, 16'h3A43, 16'h3A42, 16'h0F41}) begin
      errors++;
      $display("FAIL b2b_ram0: %h, required %h", ram[0],
               {16'h3A44, 16'h3A43, 16'h3A42, 16'h0F41});
    end
    checks++;
    if (cur_col !== 7'd5) begin
      errors++;
      $display("FAIL b2b_col: cur_col=%0d, required 5", cur_col);
    end
  endtask

  task automatic test_ctrl();
    int n, r, base_acc;
    do_reset();
    for (int i = 0; i < 3; i++) send(8'h78, 7'h01);
    run_busy(n, r);
    base_acc = acc_cnt;
    send(8'h0D, 7'h00);
    checks++;
    if (cur_col !== 7'd0) begin
      errors++;
      $display("FAIL cr_col: cur_col=%0d, required 0", cur_col);
    end
    send(8'h08, 7'h00);
    checks++;
    if (cur_col !== 7'd0) begin
      errors++;
      $display("FAIL bs0_col: cur_col=%0d, required 0", cur_col);
    end
    checks++;
    if (acc_cnt !== base_acc) begin
      errors++;
      $display("FAIL cr_bs_noaccess: %0d accesses, required 0", acc_cnt - base_acc);
    end
    for (int i = 0; i < 3; i++) send(8'h61, 7'h01);
    run_busy(n, r);
    base_acc = acc_cnt;
    send(8'h09, 7'h00);
    checks++;
    if (cur_col !== 7'd8) begin
      errors++;
      $display("FAIL tab_col: cur_col=%0d, required 8", cur_col);
    end
    send(8'h08, 7'h00);
    checks++;
    if (cur_col !== 7'd7) begin
      errors++;
      $display("FAIL bs_col: cur_col=%0d, required 7", cur_col);
    end
    send(8'h09, 7'h00);
    send(8'h80, 7'h00);
    checks++;
    if ({cur_row, cur_col} !== {5'd0, 7'd8}) begin
      errors++;
      $display("FAIL discard_cursor: row=%0d col=%0d, required 0 8", cur_row, cur_col);
    end
    run_busy(n, r);
    checks++;
    if (acc_cnt !== base_acc) begin
      errors++;
      $display("FAIL ctrl_noaccess: %0d accesses, required 0", acc_cnt - base_acc);
    end
  endtask

  task automatic test_wrap();
    int n, r, base;
    wr_t e, o;
    do_reset();
    for (int i = 0; i < 5; i++) send(8'h0A, 7'h00);
    for (int i = 0; i < 15; i++) send(8'h09, 7'h00);
    checks++;
    if ({cur_row, cur_col} !== {5'd5, 7'd120}) begin
      errors++;
      $display("FAIL wrap_setup: row=%0d col=%0d, required 5 120", cur_row, cur_col);
    end
    for (int i = 0; i < 7; i++) send(8'h20, 7'h00);
    run_busy(n, r);
    base = obs_q.size();
    exp_q.push_back('{11'd191, 8'hC0, {4{16'h215A}}, 32'd0});
    send(8'h5A, 7'h21);
    run_busy(n, r);
    checks++;
    if (obs_q.size() - base !== 1) begin
      errors++;
      $display("FAIL wrap_count: %0d writes, required 1", obs_q.size() - base);
    end else begin
      e = exp_q.pop_front();
      o = obs_q[base];
      checks++;
      if ({o.addr, o.we, o.din} !== {e.addr, e.we, e.din}) begin
        errors++;
        $display("FAIL wrap_write: addr=%h we=%h din=%h, required addr=%h we=%h din=%h",
                 o.addr, o.we, o.din, e.addr, e.we, e.din);
      end
    end
    checks++;
    if ({cur_row, cur_col} !== {5'd6, 7'd0}) begin
      errors++;
      $display("FAIL wrap_cursor: row=%0d col=%0d, required 6 0", cur_row, cur_col);
    end
    for (int i = 0; i < 16; i++) send(8'h09, 7'h00);
    checks++;
    if ({cur_row, cur_col} !== {5'd7, 7'd0}) begin
      errors++;
      $display("FAIL tab_wrap: row=%0d col=%0d, required 7 0", cur_row, cur_col);
    end
  endtask

  task automatic test_scroll();
    int n, r, base, bad, first_bad;
    logic [63:0] want;
    do_preload();
    do_reset();
    for (int i = 0; i < 31; i++) send(8'h0A, 7'h00);
    checks++;
    if (cur_row !== 5'd31) begin
      errors++;
      $display("FAIL scroll_setup: row=%0d, required 31", cur_row);
    end
    base = obs_q.size();
    send(8'h0A, 7'h25);
    run_busy(n, r);
    checks++;
    if (n !== 2016) begin
      errors++;
      $display("FAIL scroll_busy: busy cycles %0d, required 2016", n);
    end
    checks++;
    if (r !== 0) begin
      errors++;
      $display("FAIL scroll_ready_low: in_ready high %0d busy cycles, required 0", r);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL scroll_ready_back: in_ready=%b, required 1", in_ready);
    end
    checks++;
    if (obs_q.size() - base !== 1024) begin
      errors++;
      $display("FAIL scroll_writes: %0d writes, required 1024", obs_q.size() - base);
    end
    bad = 0;
    first_bad = -1;
    for (int w = 0; w < 1024; w++) begin
      want = (w < 992) ? 64'(w + 32) : {4{16'h2520}};
      if (ram[w] !== want) begin
        bad++;
        if (first_bad < 0) first_bad = w;
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL scroll_ram: %0d wrong words (first %0d = %h), required 0",
               bad, first_bad, ram[first_bad]);
    end
    checks++;
    if ({cur_row, cur_col} !== {5'd31, 7'd0}) begin
      errors++;
      $display("FAIL scroll_cursor: row=%0d col=%0d, required 31 0", cur_row, cur_col);
    end
  endtask

  task automatic test_ff();
    int n, r, base, bad;
    wr_t e, o;
    send(8'h71, 7'h00);
    run_busy(n, r);
    base = obs_q.size();
    for (int i = 0; i < 1024; i++) exp_q.push_back('{11'(i), 8'hFF, 64'h1020_1020_1020_1020, 32'd0});
    send(8'h0C, 7'h10);
    run_busy(n, r);
    checks++;
    if (n !== 1024) begin
      errors++;
      $display("FAIL ff_busy: busy cycles %0d, required 1024", n);
    end
    checks++;
    if (obs_q.size() - base !== 1024) begin
      errors++;
      $display("FAIL ff_writes: %0d writes, required 1024", obs_q.size() - base);
      exp_q.delete();
    end else begin
      bad = 0;
      for (int i = 0; i < 1024; i++) begin
        e = exp_q.pop_front();
        o = obs_q[base + i];
        if ({o.addr, o.we, o.din} !== {e.addr, e.we, e.din}) bad++;
      end
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL ff_data: %0d wrong writes, required 0", bad);
      end
    end
    checks++;
    if ({cur_row, cur_col} !== 12'd0) begin
      errors++;
      $display("FAIL ff_cursor: row=%0d col=%0d, required 0 0", cur_row, cur_col);
    end
  endtask

  task automatic test_abort();
    int n, base, base_acc;
    do_preload();
    do_reset();
    for (int i = 0; i < 31; i++) send(8'h0A, 7'h00);
    send(8'h0A, 7'h00);
    n = 0;
    @(negedge clk_data);
    while (!(mem_en && mem_we == 8'h00 && mem_addr == 11'd500) && n < 3000) begin
      @(negedge clk_data);
      n++;
    end
    checks++;
    if (!(mem_en && mem_we == 8'h00 && mem_addr == 11'd500)) begin
      errors++;
      $display("FAIL abort_reach: read of word 500 not seen in %0d cycles, required seen", n);
    end
    irst = 1'b1;
    #1;
    base = obs_q.size();
    base_acc = acc_cnt;
    @(negedge clk_data);
    checks++;
    if ({mem_en, mem_we, busy} !== 10'd0) begin
      errors++;
      $display("FAIL abort_port: en=%b we=%h busy=%b, required 0", mem_en, mem_we, busy);
    end
    checks++;
    if ({cur_row, cur_col} !== 12'd0) begin
      errors++;
      $display("FAIL abort_cursor: row=%0d col=%0d, required 0 0", cur_row, cur_col);
    end
    @(posedge clk_data);
    #1 irst = 1'b0;
    repeat (4) @(negedge clk_data);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: in_ready=%b busy=%b, required 1 0", in_ready, busy);
    end
    checks++;
    if (obs_q.size() !== base || acc_cnt !== base_acc) begin
      errors++;
      $display("FAIL abort_nowrite: %0d accesses after reset, required 0", acc_cnt - base_acc);
    end
    checks++;
    if ({ram[467], ram[468], ram[900]} !== {64'd499, 64'd468, 64'd900}) begin
      errors++;
      $display("FAIL abort_ram: w467=%0d w468=%0d w900=%0d, required 499 468 900",
               ram[467], ram[468], ram[900]);
    end
  endtask

  initial begin
    test_reset();
    test_put();
    test_back_to_back();
    test_ctrl();
    test_wrap();
    test_scroll();
    test_ff();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tty_writer.md
TTY_WRITER -- requirements
Module: tty_writer

Interface
REQ-001 Parameter COLS, default 128, text columns per row.
REQ-002 Parameter ROWS, default 32, text rows.
REQ-003 Parameter WPR, default 32, 64-bit words per row (COLS/4).
REQ-004 clk_data  in  1  write-side clock; all logic on rising edge.
REQ-005 irst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  character byte offered.
REQ-007 in_char  in  8  ASCII byte.
REQ-008 in_attr  in  7  {bg[2:0], fg[3:0]}, sampled with in_char.
REQ-009 in_ready  out  1  block accepts a byte this cycle.
REQ-010 mem_en  out  1  framebuffer port enable.
REQ-011 mem_we  out  8  byte-lane write enables; 0 = read.
REQ-012 mem_addr  out  11  word address {row[4:0], colword[4:0]}.
REQ-013 mem_din  out  64  write data.
REQ-014 mem_dout  in  64  read data, valid the cycle after a read (mem_en=1, mem_we=0).
REQ-015 cur_row  out  5  cursor row; cur_col  out  7  cursor column.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 Cell = 16 bits {1'b0, bg[2:0], fg[3:0], char[7:0]}; cell col c occupies bits [16*(c%4)+15 : 16*(c%4)] of word {row, c/4}.
REQ-018 States: IDLE, PUT, SCR_RD, SCR_WR, CLR_ROW, CLR_ALL.
REQ-019 in_ready = 1 only in IDLE; transfer occurs when in_valid & in_ready.
REQ-020 Printable 0x20-0x7E: IDLE->PUT; in PUT, mem_en=1, mem_addr={cur_row,cur_col[6:2]}, mem_din = cell replicated x4, mem_we = 2'b11 << 2*cur_col[1:0]; next state IDLE; throughput 1 byte per 2 cycles.
REQ-021 After PUT, cur_col+1; at cur_col=127 instead cur_col=0 and newline per REQ-024.
REQ-022 0x0D (CR): cur_col=0, stay IDLE, no memory access.
REQ-023 0x08 (BS): cur_col-1 if cur_col>0, else unchanged; no erase.
REQ-024 0x0A (LF)/newline: if cur_row<31 cur_row+1, stay IDLE; if cur_row=31 enter SCR_RD with copy index k=32 (row 1, word 0); cur_row stays 31.
REQ-025 0x09 (TAB): cur_col = (cur_col|7)+1; if this exceeds 127, behave as wrap (REQ-021).
REQ-026 0x0C (FF): enter CLR_ALL; cur_row=0, cur_col=0 on completion.
REQ-027 All other bytes accepted and discarded, no state change.
REQ-028 SCR_RD: read word k; SCR_WR: write mem_dout to word k-32 with mem_we=8'hFF; k+1; repeat for k=32..1023 (992 copies, 1984 cycles).
REQ-029 After last copy, CLR_ROW writes 32 words of row 31 (addr 992..1023), one per cycle, data = blank cell {attr,8'h20} x4 using the attr of the byte that caused the scroll, then IDLE.
REQ-030 CLR_ALL writes all 1024 words, addr 0..1023, one per cycle, blank cell with in_attr of the FF byte, then IDLE.
REQ-031 mem_en=0 and mem_we=0 whenever no access is specified.
REQ-032 Latency: newline with scroll -> in_ready returns after exactly 1984+32+1 cycles; FF -> 1024+1 cycles.

Reset
REQ-033 irst overrides all: state IDLE, cur_row=0, cur_col=0, mem_en=0, mem_we=0, mem_addr=0, mem_din=0, busy=0; in_ready=1 from the first cycle after reset release.
REQ-034 irst during SCR_*/CLR_* aborts immediately; no further writes; partially scrolled content is left as is.

Structure
REQ-035 Package tty_pkg holds COLS, ROWS, WPR, state enum, control codes (CR, LF, BS, TAB, FF) and the cell field widths.
REQ-036 Single module, no sub-module; copy/clear counters share one 10-bit word index.

Verification
REQ-037 Reset, send 'A' attr 7'h0F -> one write, addr 0, mem_we=8'h03, mem_din[15:0]=16'h0F41; cur_col=1.
REQ-038 Cursor at col 127 row 5, send 'Z' -> write addr {5,31}, mem_we=8'hC0; then cur_col=0, cur_row=6.
REQ-039 Row 31, send LF with model RAM preloaded word n = n -> afterwards word n = n+32 for n<992, words 992..1023 = blank cells, busy high 2016 cycles, in_ready low throughout.
REQ-040 Send FF attr 7'h10 -> 1024 writes of 64'h1020_1020_1020_1020, cursor (0,0).
REQ-041 Send CR, BS at col 0, TAB at col 3, byte 0x80 -> cur_col 0, 0, 8, 8; no memory writes.
REQ-042 Assert irst mid-scroll at k=500 -> next cycle mem_en=0, state IDLE, cursor (0,0), in_ready=1 after release.
